serial_addsub: RTL

Bit-serial 8-bit add/subtract stage that sits directly downstream of the operand inverter in the ALU datapath. It consumes operand A, the conditionally inverted operand B, and the carry-in, tied to the inverter's `inv` control, so that `inv=1` yields A − B in two's complement. It processes one bit per clock, LSB first, and presents a registered 8-bit result with carry, signed-overflow and zero flags, using a start/busy/done handshake.

---
 rtl/serial_addsub.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Bit-serial 8-bit adder/subtractor: one bit per clock, LSB first, with a
// start/busy/done handshake and registered sum, carry, overflow and zero flags.
module serial_addsub (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B_inv,
    input  logic       cin,
    output logic       busy,
    output logic       done,
    output logic [7:0] sum,
    output logic       cout,
    output logic       ovf,
    output logic       zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_sh_q, a_sh_d;
    logic [7:0] b_sh_q, b_sh_d;
    logic       carry_q, carry_d;
    logic       c_into_msb_q, c_into_msb_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic       cout_q, cout_d;
    logic       ovf_q, ovf_d;
    logic       zero_q, zero_d;

    logic       bit_s;
    logic       bit_c;

    // One full-adder slice on the current LSBs.
    assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        carry_d      = carry_q;
        c_into_msb_d = c_into_msb_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B_inv;
                    carry_d = cin;
                    cnt_d   = 3'd0;
                    acc_d   = 8'h00;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                a_sh_d  = {1'b0, a_sh_q[7:1]};
                b_sh_d  = {1'b0, b_sh_q[7:1]};
                carry_d = bit_c;
                acc_d   = {bit_s, acc_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                // Last bit: carry_q is the carry into bit 7, bit_c the carry out.
                if (cnt_q == 3'd7) begin
                    c_into_msb_d = carry_q;
                    sum_d        = acc_d;
                    cout_d       = bit_c;
                    ovf_d        = carry_q ^ bit_c;
                    zero_d       = (acc_d == 8'h00);
                    state_d      = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register
    // here is a plain flop, so all of them are cleared by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= 8'h00;
            b_sh_q       <= 8'h00;
            carry_q      <= 1'b0;
            c_into_msb_q <= 1'b0;
            acc_q        <= 8'h00;
            cnt_q        <= 3'd0;
            sum_q        <= 8'h00;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            carry_q      <= carry_d;
            c_into_msb_q <= c_into_msb_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            ovf_q        <= ovf_d;
            zero_q       <= zero_d;
        end
    end

    // Handshake outputs decode the registered state only.
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
